// File: rtl/tcm_loader_pkg.sv
// Shared types and constants for the TCM boot loader and its input FIFO.
package tcm_loader_pkg;

    localparam int          WORD_W  = 32;
    localparam logic [3:0]  WE_FULL = 4'hF;
    localparam int          CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        RST,
        DONE
    } state_t;

endpackage

// File: rtl/tcm_loader_fifo.sv
// Synchronous FIFO with an asynchronous active-high reset.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module tcm_loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tcm_boot_loader.sv
// Streams (addr, instruction) words into the TCM, then pulses the core reset.
// Optional checksum_o output enabled by defining TCM_BOOT_LOADER_CHECKSUM_EN.
module tcm_boot_loader
    import tcm_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_HOLD = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] in_addr_i,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic [3:0]        tb_inst_we_o,
    output logic [WORD_W-1:0] tb_inst_addr_o,
    output logic [WORD_W-1:0] tb_inst_data_o,
    output logic              rst_cpu_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  word_count_o
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0] checksum_o
`endif
);

    localparam int                HW        = $clog2(RESET_HOLD + 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(RESET_HOLD - 1);

    state_t              state, state_n;
    logic [HW-1:0]       hold_cnt;
    logic                fifo_full, fifo_empty;
    logic [2*WORD_W-1:0] fifo_head;
    logic                accept, aligned, good, fifo_push, wr_fire, session_start;
    logic [WORD_W-1:0]   wr_addr, wr_data;

    assign in_ready_o    = (state == LOAD) && !fifo_full;
    assign accept        = in_valid_i && in_ready_o;
    assign aligned       = (in_addr_i[1:0] == 2'b00);
    assign good          = accept && aligned;
    assign session_start = start_i && ((state == IDLE) || (state == DONE));

    // An empty FIFO is bypassed so a fresh word reaches the TCM one cycle after acceptance.
    assign fifo_push = good && !fifo_empty;
    assign wr_fire   = !fifo_empty || good;
    assign wr_addr   = fifo_empty ? in_addr_i : fifo_head[2*WORD_W-1:WORD_W];
    assign wr_data   = fifo_empty ? in_data_i : fifo_head[WORD_W-1:0];

    tcm_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*WORD_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fifo_push),
        .pop   (!fifo_empty),
        .wdata ({in_addr_i, in_data_i}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .data  (fifo_head)
    );

    assign rst_cpu_o = (state == RST);
    assign busy_o    = (state == LOAD) || (state == DRAIN) || (state == RST);
    assign done_o    = (state == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_i) state_n = LOAD;
            LOAD:    if (accept && in_last_i) state_n = DRAIN;
            DRAIN:   if (fifo_empty && (tb_inst_we_o == '0)) state_n = RST;
            RST:     if (hold_cnt == HOLD_LAST) state_n = DONE;
            DONE:    if (start_i) state_n = LOAD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt       <= '0;
            tb_inst_we_o   <= '0;
            tb_inst_addr_o <= '0;
            tb_inst_data_o <= '0;
            word_count_o   <= '0;
            err_o          <= 1'b0;
        end else begin
            hold_cnt <= (state == RST) ? hold_cnt + 1'b1 : '0;

            tb_inst_we_o <= wr_fire ? WE_FULL : '0;
            if (wr_fire) begin
                tb_inst_addr_o <= wr_addr;
                tb_inst_data_o <= wr_data;
            end

            if (session_start)
                word_count_o <= '0;
            else if ((tb_inst_we_o == WE_FULL) && (word_count_o != '1))
                word_count_o <= word_count_o + 1'b1;

            if (session_start)
                err_o <= 1'b0;
            else if (accept && !aligned)
                err_o <= 1'b1;
        end
    end

`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            checksum_o <= '0;
        else if (session_start)
            checksum_o <= '0;
        else if (tb_inst_we_o == WE_FULL)
            checksum_o <= checksum_o + tb_inst_data_o;
    end
`endif

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Directed table-driven bench for tcm_boot_loader (default parameters).
module tb_tcm_boot_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        logic        kept;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [3:0]  we;
    logic [31:0] waddr, wdata;
    logic        rst_cpu, busy, done, err;
    logic [15:0] word_count;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int total = 0;
    int bad   = 0;
    int rst_cycles = 0;
    int ready_stalls = 0;
    logic [63:0] exp_q[$];
    vec_t tbl[22];

    always #5 clk = ~clk;

    tcm_boot_loader #(.FIFO_DEPTH(4), .RESET_HOLD(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_addr_i      (in_addr),
        .in_data_i      (in_data),
        .in_last_i      (in_last),
        .tb_inst_we_o   (we),
        .tb_inst_addr_o (waddr),
        .tb_inst_data_o (wdata),
        .rst_cpu_o      (rst_cpu),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .word_count_o   (word_count)
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
        ,
        .checksum_o     (checksum)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Write-port monitor: every TCM write must match the next expected word in order.
    always @(negedge clk) begin
        if (rst_cpu) rst_cycles++;
        if (we !== 4'h0) begin
            logic [63:0] e;
            check("write_we", {28'h0, we}, 32'hF);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", waddr, e[63:32]);
                check("write_data", wdata, e[31:0]);
            end
        end
    end

    task automatic send(input vec_t v);
        int i;
        in_valid = 1'b1;
        in_addr  = v.addr;
        in_data  = v.data;
        in_last  = v.last;
        if (v.kept) exp_q.push_back({v.addr, v.data});
        i = 0;
        while (!in_ready && i < 50) begin
            ready_stalls++;
            @(negedge clk);
            i++;
        end
        if (i >= 50) check("ready_timeout", 32'h1, 32'h0);
        @(negedge clk);
    endtask

    task automatic begin_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", {31'h0, busy}, 32'h1);
        check("start_count_clr", {16'h0, word_count}, 32'h0);
        check("start_err_clr", {31'h0, err}, 32'h0);
    endtask

    task automatic run_session(input int lo, input int hi, input int exp_cnt, input logic exp_err);
        int i;
        logic [31:0] sum;
        sum = '0;
        rst_cycles = 0;
        ready_stalls = 0;
        begin_session();
        for (int k = lo; k <= hi; k++) begin
            send(tbl[k]);
            if (tbl[k].kept) sum = sum + tbl[k].data;
            if (k == lo && tbl[k].kept) check("latency_we", {28'h0, we}, 32'hF);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        i = 0;
        while (!done && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("done_reached", {31'h0, done}, 32'h1);
        check("busy_at_done", {31'h0, busy}, 32'h0);
        check("word_count", {16'h0, word_count}, exp_cnt);
        check("err", {31'h0, err}, {31'h0, exp_err});
        check("rst_pulse_len", rst_cycles, 32'd2);
        check("all_written", exp_q.size(), 32'd0);
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
    endtask

    initial begin
        // basic load
        tbl[0]  = '{32'h0,     32'h00000013, 1'b0, 1'b1};
        tbl[1]  = '{32'h4,     32'h00100093, 1'b0, 1'b1};
        tbl[2]  = '{32'h8,     32'h00000073, 1'b1, 1'b1};
        // 8-word stream
        for (int k = 0; k < 8; k++)
            tbl[3+k] = '{32'h200 + 32'(k*4), 32'hA5000000 + 32'(k), (k == 7), 1'b1};
        // misaligned word in the middle
        tbl[11] = '{32'h0,     32'hDEAD0000, 1'b0, 1'b1};
        tbl[12] = '{32'h6,     32'hBAD00006, 1'b0, 1'b0};
        tbl[13] = '{32'h8,     32'hBEEF0008, 1'b1, 1'b1};
        // restart from DONE
        tbl[14] = '{32'h100,   32'h12345678, 1'b1, 1'b1};
        // checksum wrap
        tbl[15] = '{32'h40,    32'hFFFFFFFF, 1'b0, 1'b1};
        tbl[16] = '{32'h44,    32'h00000002, 1'b1, 1'b1};
        // reset mid-load (only the first two are sent)
        for (int k = 0; k < 5; k++)
            tbl[17+k] = '{32'h300 + 32'(k*4), 32'hC0DE0000 + 32'(k), (k == 4), 1'b1};

        repeat (3) @(negedge clk);
        check("rst_we", {28'h0, we}, 32'h0);
        check("rst_cpu", {31'h0, rst_cpu}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_count", {16'h0, word_count}, 32'h0);
        check("rst_ready", {31'h0, in_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'h0, in_ready}, 32'h0);

        run_session(0, 2, 3, 1'b0);
        run_session(3, 10, 8, 1'b0);
        check("no_backpressure", ready_stalls, 32'd0);
        run_session(11, 13, 2, 1'b1);
        run_session(14, 14, 1, 1'b0);
        run_session(15, 16, 2, 1'b0);

        // Reset mid-load after two of five words.
        rst_cycles = 0;
        begin_session();
        send(tbl[17]);
        send(tbl[18]);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_we", {28'h0, we}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_rstcpu", {31'h0, rst_cpu}, 32'h0);
        check("midrst_ready", {31'h0, in_ready}, 32'h0);
        check("midrst_written", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_pulse", rst_cycles, 32'd0);
        check("midrst_idle", {30'h0, busy, done}, 32'h0);

        // Recovery after the abort.
        run_session(0, 2, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
